// File: rtl/linreg_stream_engine.sv
// Streaming least-squares line fit: one-pass sums, one shared restoring divider for b1 then b0, optional residual pass.
// Latency: done pulses 2+2*QW cycles after the last sample handshake (QW = IW quotient bits per coefficient).
// Backpressure: s_ready is high for the whole sample pass; in the residual pass s_ready drops while a held residual waits on m_ready.
module linreg_stream_engine #(
    parameter int W     = 20,
    parameter int N_MAX = 256,
    parameter int FRAC  = 8,
    parameter int CW    = $clog2(N_MAX + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CW-1:0]       n_samples,
    input  logic                resid_en,
    input  logic                s_valid,
    input  logic signed [W-1:0] s_x,
    input  logic signed [W-1:0] s_y,
    output logic                s_ready,
    output logic                m_valid,
    output logic signed [W-1:0] m_e,
    input  logic                m_ready,
    output logic signed [W-1:0] b1,
    output logic signed [W-1:0] b0,
    output logic                done,
    output logic                busy,
    output logic                degen,
    output logic                sat
);
    // Sums of squares/products times N never exceed this width, so the fit is exact.
    localparam int IW = 3*W + 2*CW + FRAC + 2;
    localparam int QW = IW;
    localparam int SW = $clog2(QW);
    localparam logic [SW-1:0]       STEP_LAST = SW'(QW - 1);
    localparam logic signed [W-1:0] W_MAX     = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] W_MIN     = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_CALC, S_DIV1, S_DIV2, S_DONE, S_RESID} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        n_lat, smp_cnt;
    logic                 res_lat, pad;
    logic signed [IW-1:0] acc_x, acc_y, acc_xx, acc_xy, b1q;
    logic [SW-1:0]        stp_cnt;
    logic [IW-1:0]        dvd, dvs, rem, quo;
    logic                 q_neg;

    logic                 s_hs, step_last, degen_calc, div_load, div_run, q_bit;
    logic signed [IW-1:0] n_ext, num, den, b1_src, ld_dvd, ld_dvs, q_fin, e_full;
    logic [IW-1:0]        ld_dvd_mag, ld_dvs_mag, rem_nxt, quo_nxt;
    logic [IW:0]          rem_sh;

    function automatic logic clip(input logic signed [IW-1:0] v);
        return (v > IW'(W_MAX)) || (v < IW'(W_MIN));
    endfunction

    function automatic logic signed [W-1:0] sat_w(input logic signed [IW-1:0] v);
        if (v > IW'(W_MAX))      return W_MAX;
        else if (v < IW'(W_MIN)) return W_MIN;
        else                     return v[W-1:0];
    endfunction

    // Fit arithmetic, divider operand selection and one restoring-division step
    always_comb begin
        s_hs       = s_valid && s_ready;
        step_last  = (stp_cnt == STEP_LAST);
        n_ext      = $signed({{(IW-CW){1'b0}}, n_lat});
        num        = n_ext * acc_xy - acc_x * acc_y;
        den        = n_ext * acc_xx - acc_x * acc_x;
        degen_calc = (den == '0) || (n_lat == CW'(1));
        // On the DIV1->DIV2 hand-off the fresh b1 quotient feeds the b0 dividend directly.
        b1_src     = (state == S_DIV1) ? q_fin : b1q;
        ld_dvd     = (state == S_CALC) ? (num <<< FRAC) : ((acc_y <<< FRAC) - b1_src * acc_x);
        ld_dvs     = (state == S_CALC) ? den : (n_ext <<< FRAC);
        ld_dvd_mag = ld_dvd[IW-1] ? -ld_dvd : ld_dvd;
        ld_dvs_mag = ld_dvs[IW-1] ? -ld_dvs : ld_dvs;
        rem_sh     = {rem, dvd[IW-1]};
        q_bit      = (rem_sh >= {1'b0, dvs});
        rem_nxt    = q_bit ? IW'(rem_sh - {1'b0, dvs}) : rem_sh[IW-1:0];
        quo_nxt    = {quo[IW-2:0], q_bit};
        q_fin      = q_neg ? -$signed(quo_nxt) : $signed(quo_nxt);
        // Degenerate fits idle through a QW-cycle pad in DIV2 so done timing never depends on the data.
        div_load   = ((state == S_CALC) && !degen_calc) || ((state == S_DIV1) && step_last) ||
                     ((state == S_DIV2) && pad && step_last);
        div_run    = ((state == S_DIV1) || ((state == S_DIV2) && !pad)) && !step_last;
        e_full     = IW'(s_y) - ((IW'(b1) * IW'(s_x)) >>> FRAC) - IW'(b0);
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Next state and handshake/status outputs
    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        done      = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE:  if (start) state_nxt = (n_samples == '0) ? S_DONE : S_ACCUM;
            S_ACCUM: begin
                s_ready = 1'b1;
                if (s_hs && (smp_cnt == n_lat - CW'(1))) state_nxt = S_CALC;
            end
            S_CALC:  state_nxt = degen_calc ? S_DIV2 : S_DIV1;
            S_DIV1:  if (step_last) state_nxt = S_DIV2;
            S_DIV2:  if (step_last && !pad) state_nxt = S_DONE;
            S_DONE: begin
                done      = 1'b1;
                state_nxt = (res_lat && (n_lat != '0)) ? S_RESID : S_IDLE;
            end
            S_RESID: begin
                s_ready = (smp_cnt != n_lat) && (!m_valid || m_ready);
                if ((smp_cnt == n_lat) && m_valid && m_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Divider registers: load magnitudes on phase entry, then shift in one quotient bit per cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dvd     <= '0;
            dvs     <= '0;
            rem     <= '0;
            quo     <= '0;
            q_neg   <= 1'b0;
            stp_cnt <= '0;
        end else begin
            if ((state == S_DIV1) || (state == S_DIV2)) stp_cnt <= step_last ? '0 : stp_cnt + SW'(1);
            else                                        stp_cnt <= '0;
            if (div_load) begin
                dvd   <= ld_dvd_mag;
                dvs   <= ld_dvs_mag;
                rem   <= '0;
                quo   <= '0;
                q_neg <= ld_dvd[IW-1] ^ ld_dvs[IW-1];
            end else if (div_run) begin
                dvd <= dvd << 1;
                rem <= rem_nxt;
                quo <= quo_nxt;
            end
        end
    end

    // Run control, accumulators, coefficient outputs and the residual output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_lat   <= '0;
            res_lat <= 1'b0;
            smp_cnt <= '0;
            pad     <= 1'b0;
            acc_x   <= '0;
            acc_y   <= '0;
            acc_xx  <= '0;
            acc_xy  <= '0;
            b1q     <= '0;
            b1      <= '0;
            b0      <= '0;
            degen   <= 1'b0;
            sat     <= 1'b0;
            m_valid <= 1'b0;
            m_e     <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    n_lat   <= n_samples;
                    res_lat <= resid_en;
                    smp_cnt <= '0;
                    acc_x   <= '0;
                    acc_y   <= '0;
                    acc_xx  <= '0;
                    acc_xy  <= '0;
                    b1q     <= '0;
                    sat     <= 1'b0;
                    degen   <= (n_samples == '0);
                    if (n_samples == '0) begin
                        b1 <= '0;
                        b0 <= '0;
                    end
                end
                S_ACCUM: if (s_hs) begin
                    acc_x   <= acc_x + IW'(s_x);
                    acc_y   <= acc_y + IW'(s_y);
                    acc_xx  <= acc_xx + IW'(s_x) * IW'(s_x);
                    acc_xy  <= acc_xy + IW'(s_x) * IW'(s_y);
                    smp_cnt <= smp_cnt + CW'(1);
                end
                S_CALC: if (degen_calc) begin
                    degen <= 1'b1;
                    pad   <= 1'b1;
                end
                S_DIV1: if (step_last) b1q <= q_fin;
                S_DIV2: begin
                    if (pad) begin
                        if (step_last) pad <= 1'b0;
                    end else if (step_last) begin
                        b1      <= sat_w(b1q);
                        b0      <= sat_w(q_fin);
                        sat     <= sat | clip(b1q) | clip(q_fin);
                        smp_cnt <= '0;
                    end
                end
                S_RESID: begin
                    if (s_hs) begin
                        m_valid <= 1'b1;
                        m_e     <= sat_w(e_full);
                        sat     <= sat | clip(e_full);
                        smp_cnt <= smp_cnt + CW'(1);
                    end else if (m_ready) begin
                        m_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
